// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache-side and RAM-side bus bundle for memory_arbiter.
//   dcache : dREN, dWEN, daddr, dstore -> arbiter ; dwait, dload <- arbiter
//   icache : iREN, iaddr -> arbiter ; iwait, iload <- arbiter
//   RAM    : ramREN, ramWEN, ramaddr, ramstore <- arbiter ;
//            ramload, ramstate (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR) -> arbiter
// slave  modport: the arbiter.
// master modport: the environment (caches plus RAM).
interface memory_arbiter_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates dcache and icache word requests onto one
// single-ported RAM with a variable-latency ramstate handshake.
// Ports:
//   CLK      rising-edge clock
//   nRST     asynchronous active-low reset
//   bus      memory_arbiter_if.slave (cache handshakes + RAM strobes)
//   dcount   completed dcache accesses (wraps)
//   icount   completed icache accesses (wraps)
//   ram_err  sticky, set when RAM reports ERROR during a grant
// Parameter:
//   DBURST_MAX  dcache words per grant before a pending icache request
//               may preempt (1..15)
module memory_arbiter #(
  parameter int unsigned DBURST_MAX = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus,
  output logic [31:0]      dcount,
  output logic [31:0]      icount,
  output logic             ram_err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [4:0] BURST_LIM = 5'(DBURST_MAX);

  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

  state_t     state, next_state;
  logic [3:0] burst_cnt;
  logic       dreq, access;
  logic       d_done, i_done;

  assign dreq   = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == RS_ACCESS);

  // All RAM and cache outputs are decoded from state plus live inputs, so a
  // reset drops the strobes without waiting for a clock edge.
  always_comb begin
    next_state   = state;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    d_done       = 1'b0;
    i_done       = 1'b0;
    case (state)
      IDLE: begin
        // Arbitration cycle: no strobe, dcache wins ties.
        if (dreq)          next_state = DSERVE;
        else if (bus.iREN) next_state = ISERVE;
      end
      DSERVE: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~access;
        bus.dload    = bus.ramload;
        if (!dreq) begin
          // Request withdrawn: whatever the RAM reports is ignored.
          next_state = IDLE;
        end else begin
          d_done = access;
          // Preempt only on a word boundary once the burst quota is used up.
          if (access && bus.iREN && ({1'b0, burst_cnt} + 5'd1 >= BURST_LIM))
            next_state = ISERVE;
        end
      end
      ISERVE: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = ~access;
        bus.iload   = bus.ramload;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (access) begin
          // One icache word per grant, then hand back to a waiting dcache.
          i_done     = 1'b1;
          next_state = dreq ? DSERVE : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      burst_cnt <= '0;
      dcount    <= '0;
      icount    <= '0;
      ram_err   <= 1'b0;
    end else begin
      state <= next_state;
      // Every fresh dcache grant starts a new burst quota.
      if (next_state == DSERVE && state != DSERVE)
        burst_cnt <= '0;
      else if (d_done && ({1'b0, burst_cnt} < BURST_LIM))
        burst_cnt <= burst_cnt + 4'd1;
      if (d_done) dcount <= dcount + 32'd1;
      if (i_done) icount <= icount + 32'd1;
      if ((state == DSERVE || state == ISERVE) && bus.ramstate == RS_ERROR)
        ram_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic against a
// scoreboard. Drivers push the expected response when a request is issued;
// a monitor pops and compares whenever dwait/iwait go low.
module tb_memory_arbiter;
  localparam int DB = 4;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] dcount, icount;
  logic        ram_err;

  memory_arbiter_if bus();

  memory_arbiter #(.DBURST_MAX(DB)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus),
    .dcount(dcount), .icount(icount), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Initial content of any RAM word never written.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- RAM environment ----------------
  logic [31:0] ram_mem [logic [31:0]];
  int  cfg_lat = 0, cfg_err = 0;
  bit  rand_mode = 0;
  bit  err_seen = 0;
  int  lat_left = 0, err_left = 0;

  task automatic load_lat();
    if (rand_mode) begin
      lat_left = $urandom_range(0, 3);
      err_left = (lat_left > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, lat_left) : 0;
    end else begin
      lat_left = cfg_lat;
      err_left = cfg_err;
    end
  endtask

  initial begin
    bus.ramstate = S_FREE;
    bus.ramload  = '0;
    load_lat();
    forever begin
      @(negedge CLK);
      bus.ramload = $urandom;
      if (!nRST || !(bus.ramREN | bus.ramWEN)) begin
        bus.ramstate = S_FREE;
        load_lat();
      end else if (lat_left > 0) begin
        if (err_left > 0) begin
          bus.ramstate = S_ERR;
          err_left--;
          err_seen = 1'b1;
        end else begin
          bus.ramstate = S_BUSY;
        end
        lat_left--;
      end else begin
        bus.ramstate = S_ACC;
        if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
        else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : rom(bus.ramaddr);
        load_lat();
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct { bit wr; logic [31:0] data; } exp_t;
  exp_t        dq[$];
  logic [31:0] iq[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          d_done = 0, i_done = 0, streak = 0;
  bit          order[$];

  initial begin
    exp_t e;
    logic [31:0] ie;
    forever begin
      @(negedge CLK); #3;
      if (nRST) begin
        if (!bus.dwait) begin
          chk(bus.ramstate == S_ACC, "dwait_low_only_on_access", 32'(bus.ramstate), 32'(S_ACC));
          if (dq.size() == 0) chk(1'b0, "d_unexpected_completion", 32'd1, 32'd0);
          else begin
            e = dq.pop_front();
            if (!e.wr) chk(bus.dload == e.data, "dload", bus.dload, e.data);
          end
          chk(dcount == 32'(d_done), "dcount", dcount, 32'(d_done));
          d_done++;
          order.push_back(1'b0);
          // dcache words completed back-to-back while an icache request waits
          if (bus.iREN) begin
            streak++;
            chk(streak <= DB, "burst_limit", 32'(streak), 32'(DB));
          end else streak = 0;
        end
        if (!bus.iwait) begin
          chk(bus.ramstate == S_ACC, "iwait_low_only_on_access", 32'(bus.ramstate), 32'(S_ACC));
          if (iq.size() == 0) chk(1'b0, "i_unexpected_completion", 32'd1, 32'd0);
          else begin
            ie = iq.pop_front();
            chk(bus.iload == ie, "iload", bus.iload, ie);
          end
          chk(icount == 32'(i_done), "icount", icount, 32'(i_done));
          i_done++;
          order.push_back(1'b1);
          streak = 0;
        end
        if (!(bus.dREN | bus.dWEN)) streak = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_pt();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK); #3;
  endtask

  task automatic d_req(input bit wr, input bit ren, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    e.wr   = wr;
    e.data = wr ? v : (ref_mem.exists(a) ? ref_mem[a] : rom(a));
    dq.push_back(e);
    if (wr) ref_mem[a] = v;
    bus.daddr  = a;
    bus.dstore = v;
    bus.dWEN   = wr;
    bus.dREN   = wr ? ren : 1'b1;
  endtask

  task automatic wait_done(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      sample();
      ok = is_d ? !bus.dwait : !bus.iwait;
    end
    if (!ok) chk(1'b0, is_d ? "d_timeout" : "i_timeout", 32'd0, 32'd1);
  endtask

  task automatic d_access(input bit wr, input bit ren, input logic [31:0] a,
                          input logic [31:0] v, input bit hold);
    bit ok;
    d_req(wr, ren, a, v);
    wait_done(1'b1, ok);
    drive_pt();
    if (!hold || !ok) begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  endtask

  task automatic i_access(input logic [31:0] a);
    bit ok;
    iq.push_back(rom(a));
    bus.iaddr = a;
    bus.iREN  = 1'b1;
    wait_done(1'b0, ok);
    drive_pt();
    bus.iREN = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  wv;
    logic [6:0]  ov;
    logic [31:0] base_d;
    int          nerr;
    bit          ok;

    bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.iREN = 0; bus.iaddr = 0;

    // Reset state
    #1 nRST = 1'b0;
    #1;
    chk(bus.dwait == 1'b1, "rst_dwait", 32'(bus.dwait), 32'd1);
    chk(bus.iwait == 1'b1, "rst_iwait", 32'(bus.iwait), 32'd1);
    chk({bus.ramREN, bus.ramWEN} == 2'b00, "rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    chk(bus.ramaddr == 0 && bus.ramstore == 0, "rst_ramaddr_store", bus.ramaddr | bus.ramstore, 32'd0);
    chk(bus.dload == 0 && bus.iload == 0, "rst_loads", bus.dload | bus.iload, 32'd0);
    chk(dcount == 0 && icount == 0, "rst_counts", dcount | icount, 32'd0);
    chk(ram_err == 1'b0, "rst_ram_err", 32'(ram_err), 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // T1: single dcache read, two BUSY cycles
    cfg_lat = 2; cfg_err = 0;
    ram_mem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    drive_pt();
    d_req(1'b0, 1'b1, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sample();
      wv[3-i] = bus.dwait;
      if (i == 1) begin
        chk(bus.ramREN && !bus.ramWEN, "t1_ramREN", 32'({bus.ramREN, bus.ramWEN}), 32'b10);
        chk(bus.ramaddr == 32'h40, "t1_ramaddr", bus.ramaddr, 32'h40);
      end
      if (i == 3) chk(bus.dload == 32'hDEAD_BEEF, "t1_dload", bus.dload, 32'hDEAD_BEEF);
    end
    chk(wv == 4'b1110, "t1_dwait_sequence", 32'(wv), 32'b1110);
    drive_pt();
    bus.dREN = 1'b0;
    sample();
    chk(dcount == 1, "t1_dcount", dcount, 32'd1);
    chk(icount == 0, "t1_icount", icount, 32'd0);

    // T2: simultaneous dcache and icache requests, dcache first
    cfg_lat = 1;
    drive_pt();
    d_req(1'b0, 1'b1, 32'h44, 32'h0);
    iq.push_back(rom(32'h808));
    bus.iaddr = 32'h808;
    bus.iREN  = 1'b1;
    sample(); sample();
    chk(bus.ramaddr == 32'h44, "t2_ramaddr_d", bus.ramaddr, 32'h44);
    chk(bus.iwait == 1'b1, "t2_iwait_held", 32'(bus.iwait), 32'd1);
    wait_done(1'b1, ok);
    drive_pt();
    bus.dREN = 1'b0;
    wait_done(1'b0, ok);
    chk(bus.ramaddr == 32'h808, "t2_ramaddr_i", bus.ramaddr, 32'h808);
    drive_pt();
    bus.iREN = 1'b0;
    sample();
    chk(icount == 1, "t2_icount", icount, 32'd1);

    // T3: 6-word dcache write burst with icache pending
    cfg_lat = 0;
    base_d = dcount;
    order.delete();
    drive_pt();
    fork
      begin
        for (int k = 0; k < 6; k++)
          d_access(1'b1, 1'b0, 32'h100 + 32'(k), $urandom, k < 5);
      end
      begin
        i_access(32'h80C);
      end
    join
    ov = '0;
    foreach (order[k]) ov = {ov[5:0], order[k]};
    chk(order.size() == 7 && ov == 7'b0000100, "t3_grant_order", 32'(ov), 32'b0000100);
    sample();
    chk(dcount - base_d == 6, "t3_dcount_delta", dcount - base_d, 32'd6);
    chk(icount == 2, "t3_icount", icount, 32'd2);

    // T4: dREN and dWEN together is a write
    cfg_lat = 1;
    drive_pt();
    d_req(1'b1, 1'b1, 32'h104, 32'h1234_5678);
    sample(); sample();
    chk({bus.ramWEN, bus.ramREN} == 2'b10, "t4_strobes", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
    chk(bus.ramstore == 32'h1234_5678, "t4_ramstore", bus.ramstore, 32'h1234_5678);
    wait_done(1'b1, ok);
    drive_pt();
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    for (int k = 0; k < 6; k++) d_access(1'b0, 1'b1, 32'h100 + 32'(k), 32'h0, 1'b0);
    chk(ram_err == 1'b0, "t4_no_err_yet", 32'(ram_err), 32'd0);

    // T5: three ERROR cycles in ISERVE, then ACCESS
    cfg_lat = 3; cfg_err = 3;
    drive_pt();
    iq.push_back(rom(32'h810));
    bus.iaddr = 32'h810;
    bus.iREN  = 1'b1;
    nerr = 0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      sample();
      if (bus.ramstate == S_ERR) begin
        nerr++;
        chk(bus.iwait == 1'b1, "t5_iwait_on_error", 32'(bus.iwait), 32'd1);
      end
      ok = !bus.iwait;
    end
    chk(ok, "t5_completion", 32'(ok), 32'd1);
    chk(nerr == 3, "t5_error_cycles", 32'(nerr), 32'd3);
    chk(ram_err == 1'b1, "t5_ram_err_set", 32'(ram_err), 32'd1);
    drive_pt();
    bus.iREN = 1'b0;
    cfg_err = 0;
    repeat (3) sample();
    chk(ram_err == 1'b1, "t5_ram_err_sticky", 32'(ram_err), 32'd1);
    chk(icount == 3, "t5_icount", icount, 32'd3);

    // T6: reset in the middle of a BUSY dcache access
    cfg_lat = 5;
    drive_pt();
    bus.daddr = 32'h48;
    bus.dREN  = 1'b1;
    repeat (3) sample();
    chk(bus.ramREN == 1'b1, "t6_busy_strobe", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk({bus.ramREN, bus.ramWEN} == 2'b00, "t6_strobes_drop", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    chk(dcount == 0 && icount == 0, "t6_counts_clear", dcount | icount, 32'd0);
    chk(ram_err == 1'b0, "t6_ram_err_clear", 32'(ram_err), 32'd0);
    bus.dREN = 1'b0;
    dq.delete(); iq.delete();
    d_done = 0; i_done = 0; err_seen = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    cfg_lat = 1;
    drive_pt();
    i_access(32'h814);
    sample();
    chk(icount == 1, "t6_icount_after_reset", icount, 32'd1);

    // Random traffic: random latency and occasional ERROR cycles
    rand_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int gap;
          gap = $urandom_range(0, 2);
          d_access(1'($urandom), 1'($urandom), 32'h100 + 32'($urandom_range(0, 7)),
                   $urandom, gap == 0 && k < 59);
          repeat (gap) drive_pt();
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) drive_pt();
          i_access(32'h800 + 32'(4 * $urandom_range(0, 15)));
        end
      end
    join
    repeat (3) sample();
    chk(dcount == 32'(d_done), "rand_dcount", dcount, 32'(d_done));
    chk(icount == 32'(i_done), "rand_icount", icount, 32'(i_done));
    chk(ram_err == err_seen, "rand_ram_err", 32'(ram_err), 32'(err_seen));
    chk(dq.size() == 0 && iq.size() == 0, "scoreboard_drained", 32'(dq.size() + iq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
